reg_status_file: RTL and testbench
==================================

# reg_status_file

Parametrised architectural register file with per-register rename status for the out-of-order core. Each register holds a value, a busy bit, and the ROB tag of its newest in-flight producer. Decode reads two sources and renames one destination per cycle. Commit writes one value per cycle, with same-cycle forwarding to the read ports. A pipeline flush clears all rename state and leaves committed values intact.

## Interface
- XLEN, 32: data width in bits.
- NREG, 32: number of architectural registers; power of 2, ≥2; register 0 is hard-wired zero.
- TAG_W, 3: ROB tag width.
- RID_W, $clog2(NREG): register index width (derived, not overridden).

- clk_in  input  1  system clock.
- rst_in  input  1  reset; synchronous, active-low.
- rdy_in  input  1  global ready; when low, all state and outputs hold.
- flush_pipline  input  1  clear all busy bits this cycle.
- rs1_en / rs2_en  input  1  sample source port k this cycle.
- rs1_id / rs2_id  input  RID_W  source register index.
- rs1_val / rs2_val  output  XLEN  registered value.
- rs1_busy / rs2_busy  output  1  registered busy bit.
- rs1_tag / rs2_tag  output  TAG_W  registered producer tag (valid only when busy).
- issue_en  input  1  rename destination.
- issue_rd  input  RID_W  destination index.
- issue_tag  input  TAG_W  ROB tag of the issuing instruction.
- commit_en  input  1  retire a result.
- commit_rd  input  RID_W  destination index.
- commit_tag  input  TAG_W  ROB tag of the retiring instruction.
- commit_val  input  XLEN  retired value.

## Operation
- State per register i: val[i] (XLEN), busy[i], tag[i] (TAG_W).
- Register 0: reads always return val=0, busy=0, tag=0. Issue and commit to register 0 are ignored.
- Priority is rst_in low, then rdy_in low (everything holds), then normal operation.
- Reset (rst_in=0 at a posedge): all val, busy and tag cleared. rsk_val, rsk_busy and rsk_tag all reset to 0.
- Commit (commit_en, rd≠0):
  - val[rd] ← commit_val, unconditionally.
  - busy[rd] ← 0 only if busy[rd]=1 and tag[rd]=commit_tag and no same-cycle issue to rd.
  - If the tag mismatches, a newer producer is still pending and busy/tag are unchanged.
- Issue (issue_en, rd≠0, flush_pipline=0): busy[rd] ← 1 and tag[rd] ← issue_tag. Issue wins over a same-cycle commit clear on the same rd.
- Flush: every busy[i] ← 0; tag values are don't-care. A same-cycle commit still writes val. A same-cycle issue is dropped.
- Read port k (rsk_en=1), next-state of the outputs:
  - If rsk_id = commit_rd and commit_en, and busy[id]=1 with tag[id]=commit_tag: output val=commit_val, busy=0. This is commit forwarding.
  - Else if rsk_id = commit_rd and commit_en, with busy=0 or a tag mismatch: val=commit_val; busy and tag are taken from the pre-commit state.
  - Else: val, busy and tag are taken from current state.
  - A same-cycle issue to the same register is **not** visible, so an instruction's sources are read before its own destination is renamed.
  - A same-cycle flush is **not** visible to the read. Decode discards reads in a flush cycle.
- rsk_en=0: the port outputs hold their previous values.

## Timing
- Read latency: 1 cycle. Inputs sampled at posedge N; outputs valid after posedge N until the next enabled sample.
- Issue, commit and flush take effect at the posedge they are sampled. A read at N+1 observes them.
- No combinational input-to-output paths; all outputs are registered.
- rdy_in low for M cycles: the block is frozen and resumes exactly where it stopped. No events are lost, provided the drivers hold their inputs.
- Reset mid-operation: state is cleared on the same posedge regardless of the other inputs.
- One issue, one commit and two reads are sustainable every cycle.

## Test plan
- Reset then read: rst_in=0 for 2 cycles, then read r5 and r31 → val=0, busy=0.
- Issue then commit: issue r3 with tag 2; next cycle read r3 → busy=1, tag=2. Commit r3, tag 2, val 0xDEADBEEF; next read → val=0xDEADBEEF, busy=0.
- Stale commit: issue r4 with tag 1, then issue r4 with tag 5, then commit r4 tag 1 val 7. Read → val=7, busy=1, tag=5.
- Same-cycle events on r6 (busy, tag 3):
  - Commit tag 3 val 9 plus read r6 in the same cycle → rs1_val=9, rs1_busy=0.
  - Commit tag 3 plus issue r6 tag 4 in the same cycle → next read busy=1, tag=4.
- Flush: issue r1, r2, r7 with tags 0–2. Flush plus commit r2 tag 1 val 0x55 plus issue r8 in the same cycle. Subsequent reads → all busy=0, r2 val=0x55, r8 not busy.
- x0 and rdy: issue and commit r0 val 0x123 → read r0 gives 0, busy 0. With rdy_in=0 and commit r9 val 1 held for 3 cycles, r9 is unchanged until rdy_in=1.

Source files
------------

// File: rtl/reg_status_file_if.sv
// reg_status_file_if: decode/commit/read bundle for the register status file.
interface reg_status_file_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 3
);
    localparam int RID_W = $clog2(NREG);
    logic             rdy_in;
    logic             flush_pipline;
    logic             rs1_en;
    logic             rs2_en;
    logic [RID_W-1:0] rs1_id;
    logic [RID_W-1:0] rs2_id;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic             rs1_busy;
    logic             rs2_busy;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic             issue_en;
    logic [RID_W-1:0] issue_rd;
    logic [TAG_W-1:0] issue_tag;
    logic             commit_en;
    logic [RID_W-1:0] commit_rd;
    logic [TAG_W-1:0] commit_tag;
    logic [XLEN-1:0]  commit_val;
    modport master (
        output rdy_in, flush_pipline, rs1_en, rs2_en, rs1_id, rs2_id,
               issue_en, issue_rd, issue_tag, commit_en, commit_rd, commit_tag, commit_val,
        input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
    );
    modport slave (
        input  rdy_in, flush_pipline, rs1_en, rs2_en, rs1_id, rs2_id,
               issue_en, issue_rd, issue_tag, commit_en, commit_rd, commit_tag, commit_val,
        output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
    );
endinterface

// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file with per-register busy bit and producer tag,
// two registered read ports with commit forwarding, one rename and one commit per cycle.
module reg_status_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 3
) (
    input logic              clk_in,
    input logic              rst_in,
    reg_status_file_if.slave bus
);
    localparam int RID_W = $clog2(NREG);
    logic [XLEN-1:0]  val_q [NREG];
    logic [XLEN-1:0]  val_d [NREG];
    logic [TAG_W-1:0] tag_q [NREG];
    logic [TAG_W-1:0] tag_d [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]  rv_q [2];
    logic [XLEN-1:0]  rv_d [2];
    logic [TAG_W-1:0] rt_q [2];
    logic [TAG_W-1:0] rt_d [2];
    logic [1:0]       rb_q, rb_d;
    logic [RID_W-1:0] id [2];
    logic [1:0]       en, hit;
    logic             cm, is, retire;
    assign id[0] = bus.rs1_id;
    assign id[1] = bus.rs2_id;
    assign en    = {bus.rs2_en, bus.rs1_en};
    always_comb begin
        cm     = bus.commit_en && bus.commit_rd != '0;
        is     = bus.issue_en && bus.issue_rd != '0 && !bus.flush_pipline;
        retire = cm && busy_q[bus.commit_rd] && tag_q[bus.commit_rd] == bus.commit_tag;
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (cm)
            val_d[bus.commit_rd] = bus.commit_val;
        // a rename of the same register outranks the retirement clear
        if (retire && !(is && bus.issue_rd == bus.commit_rd))
            busy_d[bus.commit_rd] = 1'b0;
        if (is) begin
            busy_d[bus.issue_rd] = 1'b1;
            tag_d[bus.issue_rd]  = bus.issue_tag;
        end
        if (bus.flush_pipline)
            busy_d = '0;
        hit = '0;
        for (int k = 0; k < 2; k++) begin
            hit[k]  = cm && id[k] == bus.commit_rd;
            rv_d[k] = en[k] ? (hit[k] ? bus.commit_val : val_q[id[k]]) : rv_q[k];
            rb_d[k] = en[k] ? (busy_q[id[k]] && !(hit[k] && retire)) : rb_q[k];
            rt_d[k] = en[k] ? tag_q[id[k]] : rt_q[k];
        end
    end
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            val_q  <= '{default: '0};
            tag_q  <= '{default: '0};
            busy_q <= '0;
            rv_q   <= '{default: '0};
            rt_q   <= '{default: '0};
            rb_q   <= '0;
        end else if (bus.rdy_in) begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
            rv_q   <= rv_d;
            rt_q   <= rt_d;
            rb_q   <= rb_d;
        end
    end
    assign bus.rs1_val  = rv_q[0];
    assign bus.rs2_val  = rv_q[1];
    assign bus.rs1_busy = rb_q[0];
    assign bus.rs2_busy = rb_q[1];
    assign bus.rs1_tag  = rt_q[0];
    assign bus.rs2_tag  = rt_q[1];
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: directed plan plus random traffic; a model predicts each read and
// a monitor pops predictions whenever a read was sampled, otherwise checks the ports hold.
module tb_reg_status_file;
    typedef struct packed {
        logic [31:0] v;
        logic        b;
        logic [2:0]  t;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    reg_status_file_if bus ();
    reg_status_file dut (.clk_in(clk), .rst_in(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    logic [31:0] m_val [32];
    logic        m_busy [32];
    logic [2:0]  m_tag [32];
    exp_t q1[$];
    exp_t q2[$];
    function automatic exp_t peek(input logic [4:0] r);
        exp_t e;
        e = '0;
        if (r != 0) begin
            e.v = m_val[r];
            e.b = m_busy[r];
            e.t = m_tag[r];
            if (bus.commit_en && bus.commit_rd == r) begin
                e.v = bus.commit_val;
                if (m_busy[r] && m_tag[r] == bus.commit_tag) e.b = 1'b0;
            end
        end
        return e;
    endfunction
    task automatic model_step();
        logic [4:0] c, d;
        logic       iss;
        c   = bus.commit_rd;
        d   = bus.issue_rd;
        iss = bus.issue_en && d != 0 && !bus.flush_pipline;
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (bus.rdy_in) begin
            if (bus.rs1_en) q1.push_back(peek(bus.rs1_id));
            if (bus.rs2_en) q2.push_back(peek(bus.rs2_id));
            if (bus.commit_en && c != 0) begin
                if (m_busy[c] && m_tag[c] == bus.commit_tag && !(iss && d == c)) m_busy[c] = 1'b0;
                m_val[c] = bus.commit_val;
            end
            if (iss) begin
                m_busy[d] = 1'b1;
                m_tag[d]  = bus.issue_tag;
            end
            if (bus.flush_pipline)
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end
    endtask
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask
    task automatic idle();
        bus.rdy_in = 1'b1; bus.flush_pipline = 1'b0;
        bus.rs1_en = 1'b0; bus.rs2_en = 1'b0; bus.rs1_id = '0; bus.rs2_id = '0;
        bus.issue_en = 1'b0; bus.issue_rd = '0; bus.issue_tag = '0;
        bus.commit_en = 1'b0; bus.commit_rd = '0; bus.commit_tag = '0; bus.commit_val = '0;
    endtask
    task automatic chk(input string nm, input exp_t e, input logic [31:0] v, input logic b,
                       input logic [2:0] t, input logic full);
        total++;
        if (v !== e.v || b !== e.b || ((e.b || full) && t !== e.t)) begin
            bad++;
            $display("FAIL %s: got val=%h busy=%b tag=%0d, want val=%h busy=%b tag=%0d",
                     nm, v, b, t, e.v, e.b, e.t);
        end
    endtask
    // monitor: what happened at the last posedge decides how the ports are judged
    logic s_rst = 1'b1, s1 = 1'b0, s2 = 1'b0;
    exp_t last1 = '0, last2 = '0;
    always @(posedge clk) begin
        s_rst <= !rst;
        s1    <= rst && bus.rdy_in && bus.rs1_en;
        s2    <= rst && bus.rdy_in && bus.rs2_en;
    end
    always @(negedge clk) begin
        if (s_rst) begin
            last1 = '0;
            last2 = '0;
            chk("rst1", last1, bus.rs1_val, bus.rs1_busy, bus.rs1_tag, 1'b1);
            chk("rst2", last2, bus.rs2_val, bus.rs2_busy, bus.rs2_tag, 1'b1);
        end else begin
            if (s1) begin
                if (q1.size() == 0) begin
                    total++; bad++; $display("FAIL rs1_underflow: got read, want none");
                end else begin
                    last1 = q1.pop_front();
                    chk("rs1", last1, bus.rs1_val, bus.rs1_busy, bus.rs1_tag, 1'b0);
                end
            end else chk("rs1_hold", last1, bus.rs1_val, bus.rs1_busy, bus.rs1_tag, 1'b0);
            if (s2) begin
                if (q2.size() == 0) begin
                    total++; bad++; $display("FAIL rs2_underflow: got read, want none");
                end else begin
                    last2 = q2.pop_front();
                    chk("rs2", last2, bus.rs2_val, bus.rs2_busy, bus.rs2_tag, 1'b0);
                end
            end else chk("rs2_hold", last2, bus.rs2_val, bus.rs2_busy, bus.rs2_tag, 1'b0);
        end
    end
    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        bus.rs1_en = 1'b1; bus.rs1_id = a; bus.rs2_en = 1'b1; bus.rs2_id = b;
    endtask
    task automatic iss(input logic [4:0] r, input logic [2:0] t);
        bus.issue_en = 1'b1; bus.issue_rd = r; bus.issue_tag = t;
    endtask
    task automatic com(input logic [4:0] r, input logic [2:0] t, input logic [31:0] v);
        bus.commit_en = 1'b1; bus.commit_rd = r; bus.commit_tag = t; bus.commit_val = v;
    endtask
    initial begin
        idle();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        idle(); rd(5, 31); tick();
        idle(); iss(3, 2); tick();
        idle(); rd(3, 3); tick();
        idle(); com(3, 2, 32'hDEADBEEF); tick();
        idle(); rd(3, 0); tick();
        idle(); iss(4, 1); tick();
        idle(); iss(4, 5); tick();
        idle(); com(4, 1, 7); tick();
        idle(); rd(4, 4); tick();
        idle(); iss(6, 3); tick();
        idle(); com(6, 3, 9); rd(6, 6); tick();
        idle(); iss(6, 3); tick();
        idle(); com(6, 3, 10); iss(6, 4); tick();
        idle(); rd(6, 6); tick();
        idle(); iss(1, 0); tick();
        idle(); iss(2, 1); tick();
        idle(); iss(7, 2); tick();
        idle(); bus.flush_pipline = 1'b1; com(2, 1, 32'h55); iss(8, 6); tick();
        idle(); rd(1, 2); tick();
        idle(); rd(7, 8); tick();
        idle(); iss(0, 3); com(0, 3, 32'h123); tick();
        idle(); rd(0, 0); tick();
        idle(); com(9, 0, 32'hAA); tick();
        idle(); rd(9, 9); tick();
        idle(); bus.rdy_in = 1'b0; com(9, 0, 1); rd(9, 9); tick(); tick(); tick();
        bus.rdy_in = 1'b1; tick();
        idle(); rd(9, 9); tick();
        for (int n = 0; n < 600; n++) begin
            rst               = $urandom_range(0, 199) != 0;
            bus.rdy_in        = $urandom_range(0, 7) != 0;
            bus.flush_pipline = $urandom_range(0, 15) == 0;
            bus.rs1_en        = 1'($urandom_range(0, 1));
            bus.rs2_en        = 1'($urandom_range(0, 1));
            bus.rs1_id        = 5'($urandom_range(0, 3) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            bus.rs2_id        = 5'($urandom_range(0, 3) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            bus.issue_en      = 1'($urandom_range(0, 1));
            bus.issue_rd      = 5'($urandom_range(0, 7));
            bus.issue_tag     = 3'($urandom_range(0, 7));
            bus.commit_en     = 1'($urandom_range(0, 1));
            bus.commit_rd     = 5'($urandom_range(0, 7));
            bus.commit_tag    = 3'($urandom_range(0, 7));
            bus.commit_val    = $urandom;
            tick();
        end
        rst = 1'b1;
        idle(); tick(); tick(); tick();
        total++;
        if (q1.size() != 0 || q2.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending=%0d/%0d, want 0/0", q1.size(), q2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
